// File: rtl/aes_out_misr.sv
// Compresses AES ciphertext into a MISR signature after skipping the pipeline fill.
// Latency: first fold on the (LATENCY+1)th enabled edge after start; one fold per enabled edge after that.
// Backpressure: none; enable=0 freezes all state (only out_valid drops), start outside IDLE/DONE is ignored.
module aes_out_misr #(
    parameter int unsigned          WIDTH     = 128,
    parameter int unsigned          LATENCY   = 21,
    parameter logic [WIDTH-1:0]     MISR_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             start,
    input  logic [31:0]      num_tests,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] signature,
    output logic [31:0]      count,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned    FW        = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam int unsigned    LAST_FILL = (LATENCY > 0) ? LATENCY - 1 : 0;
    localparam logic [WIDTH-1:0] POLY    = WIDTH'(8'h87);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_COMPRESS,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [FW-1:0]    r_fill;
    logic [31:0]      r_num;
    logic [31:0]      r_count;
    logic [WIDTH-1:0] r_sig;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_fold_en;
    logic             w_last;
    logic             w_fill_en;
    logic [WIDTH-1:0] w_fold;

    assign w_accept  = enable && start && (r_state == S_IDLE || r_state == S_DONE);
    assign w_fill_en = enable && (r_state == S_FILL);
    assign w_fold_en = enable && (r_state == S_COMPRESS);
    assign w_last    = ((r_count + 32'd1) == r_num);
    assign w_fold    = {r_sig[WIDTH-2:0], 1'b0} ^ (r_sig[WIDTH-1] ? POLY : '0) ^ data_in;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (num_tests == 32'd0)
                        w_state_nxt = S_DONE;
                    else if (LATENCY == 0)
                        w_state_nxt = S_COMPRESS;
                    else
                        w_state_nxt = S_FILL;
                end
            end
            S_FILL: begin
                if (w_fill_en && (r_fill == FW'(LAST_FILL)))
                    w_state_nxt = S_COMPRESS;
            end
            S_COMPRESS: begin
                if (w_fold_en && w_last)
                    w_state_nxt = S_DONE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fill      <= '0;
            r_num       <= '0;
            r_count     <= '0;
            r_sig       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= w_fold_en;
            if (w_accept) begin
                r_sig   <= MISR_SEED;
                r_count <= '0;
                r_fill  <= '0;
                r_num   <= num_tests;
            end else if (w_fill_en) begin
                r_fill  <= r_fill + FW'(1);
            end else if (w_fold_en) begin
                // count tops out at r_num because the last fold leaves COMPRESS
                r_sig   <= w_fold;
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign signature = r_sig;
    assign count     = r_count;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == S_FILL) || (r_state == S_COMPRESS);
    assign done      = (r_state == S_DONE);

endmodule
